// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial-side and parallel-side signals of the UART receiver.
//   clk_en      oversample tick, one-cycle pulse at OVERSAMPLE x baud
//   rx_enable   1 = start-bit detection armed
//   rx          asynchronous serial line, idles high
//   data_out    last good received word
//   data_valid  one-cycle pulse: data_out updated
//   frame_error one-cycle pulse: stop bit sampled low
//   busy        receiver not idle
// master = the side driving the line and ticks (bench / link); slave = the receiver.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 clk_en;
    logic                 rx_enable;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_error;
    logic                 busy;

    modport master (
        output clk_en, rx_enable, rx,
        input  data_out, data_valid, frame_error, busy
    );

    modport slave (
        input  clk_en, rx_enable, rx,
        output data_out, data_valid, frame_error, busy
    );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1-style UART receiver (start bit, DATA_BITS data bits LSB
// first, one stop bit). The line is oversampled on clk_en ticks and every bit
// is sampled at its centre.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  uart_receiver_if.slave (clk_en, rx_enable, rx in;
//        data_out, data_valid, frame_error, busy out)
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic            clk,
    input  logic            rst,
    uart_receiver_if.slave  bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] data_q, data_nxt;
    logic                 valid_q, valid_nxt;
    logic                 ferr_q, ferr_nxt;
    logic                 rx_meta, rx_sync;

    // Two-flop synchronizer runs every clock; it resets to the idle level so
    // reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= shreg_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            ferr_q  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        data_nxt  = data_q;
        // Strobes default low every clock so they last exactly one cycle even
        // when ticks are sparse.
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        cnt_nxt   = cnt;

        if (bus.clk_en) begin
            case (state)
                IDLE: begin
                    if (bus.rx_enable && !rx_sync)
                        state_nxt = START;
                end
                START: begin
                    // Half a bit in: a high line here was a glitch.
                    if (cnt == HALF_LAST) begin
                        if (rx_sync) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DATA;
                            bit_nxt   = '0;
                        end
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        shreg_nxt = {rx_sync, shreg[DATA_BITS-1:1]};
                        bit_nxt   = bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT)
                            state_nxt = STOP;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        if (rx_sync) begin
                            data_nxt  = shreg;
                            valid_nxt = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Hold off until the line recovers so a stuck-low line
                    // cannot spin out a stream of bogus frames.
                    if (rx_sync)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase

            // Counter restarts at every state change and at each bit boundary,
            // so OVERSAMPLE need not be a power of two.
            if (state_nxt != state || cnt == BIT_LAST ||
                state == IDLE || state == BREAK)
                cnt_nxt = '0;
            else
                cnt_nxt = cnt + CW'(1);
        end
    end

    assign bus.data_out    = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.frame_error = ferr_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;
    localparam int OS = 16;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst;
    uart_receiver_if #(.DATA_BITS(8)) bus ();

    uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   vectors    = 0;
    int   miscompares = 0;
    int   valid_cnt  = 0;
    int   ferr_cnt   = 0;
    bit   busy_seen  = 0;
    int   en_div     = 1;
    exp_t q[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Oversample tick generator: one pulse every en_div cycles.
    initial begin
        int div_cnt;
        div_cnt = 0;
        bus.clk_en = 0;
        forever begin
            @(negedge clk);
            if (div_cnt >= en_div - 1) begin
                bus.clk_en = 1;
                div_cnt = 0;
            end else begin
                bus.clk_en = 0;
                div_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.busy) busy_seen = 1;
            if (bus.data_valid && bus.frame_error) begin
                vectors++;
                miscompares++;
                $display("FAIL both_strobes: got 1 expected 0");
            end
            if (bus.data_valid || bus.frame_error) begin
                if (bus.data_valid) valid_cnt++;
                if (bus.frame_error) ferr_cnt++;
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: got valid=%0d ferr=%0d expected none",
                             bus.data_valid, bus.frame_error);
                end else begin
                    e = q.pop_front();
                    check("strobe_kind", {31'd0, bus.frame_error}, {31'd0, e.is_err});
                    if (!e.is_err)
                        check("rx_data", {24'd0, bus.data_out}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (bus.clk_en) k++;
        end
    endtask

    // Drives one frame; drop_bit >= 0 clears rx_enable at that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int drop_bit);
        @(negedge clk) bus.rx = 0;
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.rx = d[i];
            if (i == drop_bit) bus.rx_enable = 0;
            wait_ticks(OS);
        end
        @(negedge clk) bus.rx = stop;
        wait_ticks(OS);
    endtask

    initial begin
        int base;
        rst = 1;
        bus.rx = 1;
        bus.rx_enable = 1;
        repeat (3) @(negedge clk);
        check("rst_data_out", {24'd0, bus.data_out}, 32'h0);
        check("rst_valid", {31'd0, bus.data_valid}, 32'h0);
        check("rst_ferr", {31'd0, bus.frame_error}, 32'h0);
        check("rst_busy", {31'd0, bus.busy}, 32'h0);
        rst = 0;
        wait_ticks(5);

        // 1: good frame 0xA5
        q.push_back('{0, 8'hA5});
        send_frame(8'hA5, 1, -1);
        @(negedge clk);
        check("t1_valid_cnt", valid_cnt, 1);
        check("t1_data", {24'd0, bus.data_out}, 32'hA5);
        check("t1_ferr_cnt", ferr_cnt, 0);
        check("t1_busy", {31'd0, bus.busy}, 32'h0);

        // 2: 4-tick glitch is rejected
        @(negedge clk) bus.rx = 0;
        wait_ticks(4);
        @(negedge clk) bus.rx = 1;
        wait_ticks(2);
        @(negedge clk);
        check("t2_busy_mid", {31'd0, bus.busy}, 32'h1);
        wait_ticks(8);
        @(negedge clk);
        check("t2_busy_end", {31'd0, bus.busy}, 32'h0);
        check("t2_valid_cnt", valid_cnt, 1);

        // 3: framing error, line held low
        q.push_back('{1, 8'h00});
        send_frame(8'h3C, 0, -1);
        wait_ticks(40);
        @(negedge clk);
        check("t3_ferr_cnt", ferr_cnt, 1);
        check("t3_data_kept", {24'd0, bus.data_out}, 32'hA5);
        check("t3_busy_break", {31'd0, bus.busy}, 32'h1);
        check("t3_valid_cnt", valid_cnt, 1);
        bus.rx = 1;
        wait_ticks(4);
        @(negedge clk);
        check("t3_busy_idle", {31'd0, bus.busy}, 32'h0);

        // 4: back-to-back 0x00, 0xFF with a tick every 3rd cycle
        en_div = 3;
        wait_ticks(4);
        base = valid_cnt;
        q.push_back('{0, 8'h00});
        q.push_back('{0, 8'hFF});
        send_frame(8'h00, 1, -1);
        send_frame(8'hFF, 1, -1);
        wait_ticks(4);
        @(negedge clk);
        check("t4_valid_cnt", valid_cnt, base + 2);
        check("t4_data", {24'd0, bus.data_out}, 32'hFF);
        en_div = 1;
        wait_ticks(4);

        // 5: reset in the middle of 0x81's data bits
        @(negedge clk) bus.rx = 0;
        wait_ticks(OS);
        @(negedge clk) bus.rx = 1;
        wait_ticks(OS);
        @(negedge clk) bus.rx = 0;
        wait_ticks(OS + 4);
        @(negedge clk);
        rst = 1;
        bus.rx = 1;
        #1;
        check("t5_rst_data", {24'd0, bus.data_out}, 32'h0);
        check("t5_rst_busy", {31'd0, bus.busy}, 32'h0);
        check("t5_rst_valid", {31'd0, bus.data_valid}, 32'h0);
        @(negedge clk) rst = 0;
        wait_ticks(20);
        base = valid_cnt;
        q.push_back('{0, 8'h81});
        send_frame(8'h81, 1, -1);
        @(negedge clk);
        check("t5_valid_cnt", valid_cnt, base + 1);
        check("t5_data", {24'd0, bus.data_out}, 32'h81);

        // 6: disabled receiver ignores a frame; dropping enable mid-frame does not abort
        bus.rx_enable = 0;
        busy_seen = 0;
        base = valid_cnt;
        send_frame(8'h55, 1, -1);
        wait_ticks(4);
        @(negedge clk);
        check("t6_busy_seen", {31'd0, busy_seen}, 32'h0);
        check("t6_no_valid", valid_cnt, base);
        bus.rx_enable = 1;
        wait_ticks(20);
        q.push_back('{0, 8'h55});
        send_frame(8'h55, 1, 3);
        @(negedge clk);
        check("t6_valid_cnt", valid_cnt, base + 1);
        check("t6_data", {24'd0, bus.data_out}, 32'h55);

        wait_ticks(20);
        @(negedge clk);
        check("sb_empty", q.size(), 0);
        check("ferr_total", ferr_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
